debounced_mod_counter: RTL
==========================

DEBOUNCED_MOD_COUNTER -- requirements
Module: debounced_mod_counter

Interface
REQ-001 Parameter DIV, default 10000, meaning MHz cycles per sample tick (legal range 2 to 2^20).
REQ-002 Parameter STABLE, default 7, meaning consecutive equal samples required to change a debounced level (legal range 2 to 16).
REQ-003 Parameter WIDTH, default 3, meaning count output width.
REQ-004 Parameter MODULUS, default 8, meaning count range 0..MODULUS-1 (legal range 2 to 2^WIDTH).
REQ-005 Parameter KEY_POL, default 1, meaning 1 = key pressed when high, 0 = pressed when low.
REQ-006 Port MHz  input  1  system clock; all state changes on posedge MHz.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port keys  input  3  raw asynchronous push-buttons: [0] up, [1] down, [2] clear.
REQ-009 Port counter  output  WIDTH  current count value.
REQ-010 Port key_lvl  output  3  debounced pressed level per key, 1 = pressed.
REQ-011 Port wrap  output  1  one-cycle pulse on modulo wrap in either direction.
REQ-012 Port tick  output  1  one-cycle sample strobe, exported for reuse.
REQ-013 Port led  output  1  constant 1 (power indicator).

Function
REQ-014 Keys shall pass through a 2-flop synchronizer per bit, then be XORed with ~KEY_POL so that internal 1 = pressed.
REQ-015 Tick divider shall count 0..DIV-1 and wrap to 0; tick shall be high for exactly the one cycle in which the divider equals DIV-1, giving period DIV cycles.
REQ-016 Each key shall have a STABLE-bit shift register that shifts in the synchronized level only on cycles where tick = 1.
REQ-017 A key's key_lvl shall set to 1 when all STABLE bits are 1 and clear to 0 when all are 0; otherwise it holds (hysteresis), evaluated on the same cycle the shift register updates.
REQ-018 A press event shall be a one-cycle internal pulse on the cycle after a 0->1 transition of key_lvl; releases generate no event.
REQ-019 Counter update priority shall be, on the cycle of the press pulse: clear -> 0; else up and down together -> no change; else up -> +1; else down -> -1.
REQ-020 Up from MODULUS-1 shall give 0 and down from 0 shall give MODULUS-1, each asserting wrap on the same cycle the counter changes; clear never asserts wrap.
REQ-021 Arithmetic shall be exactly WIDTH bits; the counter shall never hold a value of MODULUS or above.
REQ-022 Latency from the tick that completes the STABLE-th equal sample to the counter change shall be exactly 2 MHz cycles (key_lvl updates on cycle T, press pulse on T+1, counter on T+1 registered out at T+2).
REQ-023 Held key shall produce exactly one event, with no auto-repeat; bounces shorter than STABLE ticks shall produce no event.

Reset
REQ-024 While rst_n = 0, asynchronously: synchronizers, shift registers, key_lvl, divider, tick, wrap, press pulses and counter shall be 0; led shall remain 1.
REQ-025 After rst_n deasserts, the first tick shall occur DIV cycles later; a key held through reset shall count as one press once STABLE ticks elapse.
REQ-026 Reset asserted mid-debounce or mid-update shall discard the pending event, with no partial count change.

Verification (DIV=4, STABLE=3, WIDTH=3, MODULUS=6, KEY_POL=1)
REQ-027 Release reset, idle 40 cycles -> tick every 4th cycle, counter = 0, wrap never high.
REQ-028 Hold keys[0] for 20 ticks -> counter 0->1 exactly once, key_lvl[0] = 1, 2-cycle latency after 3rd tick.
REQ-029 Toggle keys[0] every 2 ticks for 20 ticks -> counter unchanged, key_lvl[0] stays 0.
REQ-030 Six clean up presses from 0 -> counter 1,2,3,4,5,0, wrap pulse only on the 5->0 step; one down press from 0 -> counter 5 with wrap.
REQ-031 Press up and down simultaneously -> no change; press up and clear simultaneously at count 3 -> counter 0, wrap 0.
REQ-032 Assert rst_n = 0 one tick into a press -> all outputs 0 immediately; key still held after release -> single increment to 1.

Source files
------------

// File: rtl/debounced_mod_counter.sv
// -----------------------------------------------------------------------------
// debounced_mod_counter
//
// Purpose:
//   Three push-buttons (up, down, clear) are synchronized, sampled on a slow
//   strobe, debounced with hysteresis and turned into single press events.
//   The events drive a modulo-MODULUS up/down counter that reports wrap-around.
//
// Parameters:
//   DIV      - MHz cycles per sample tick (2 .. 2^20)
//   STABLE   - consecutive equal samples needed to change a debounced level
//   WIDTH    - counter width
//   MODULUS  - counter range 0 .. MODULUS-1 (2 .. 2^WIDTH)
//   KEY_POL  - 1: key pressed when pin high, 0: pressed when pin low
//
// Ports:
//   MHz      in   system clock, every state change on its rising edge
//   rst_n    in   asynchronous active-low reset
//   keys     in   raw buttons: [0] up, [1] down, [2] clear
//   counter  out  current count value
//   key_lvl  out  debounced pressed level per key (1 = pressed)
//   wrap     out  one-cycle pulse when the counter wraps in either direction
//   tick     out  one-cycle sample strobe, period DIV cycles
//   led      out  constant 1 (power indicator)
// -----------------------------------------------------------------------------
module debounced_mod_counter #(
  parameter int DIV     = 10000,
  parameter int STABLE  = 7,
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int KEY_POL = 1
) (
  input  logic             MHz,
  input  logic             rst_n,
  input  logic [2:0]       keys,
  output logic [WIDTH-1:0] counter,
  output logic [2:0]       key_lvl,
  output logic             wrap,
  output logic             tick,
  output logic             led
);

  localparam int               DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
  // Inverting mask applied after synchronization so that 1 always means pressed.
  localparam logic [2:0]       POL_MASK = (KEY_POL != 0) ? 3'b000 : 3'b111;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer per key
  // ---------------------------------------------------------------------------
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] key_in;

  always_comb begin
    sync1_d = keys;
    sync2_d = sync1_q;
  end

  always_ff @(posedge MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign key_in = sync2_q ^ POL_MASK;

  // ---------------------------------------------------------------------------
  // Sample-tick divider
  // tick_q is registered so that it is high exactly while div_q == DIV-1.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    if (tick_q) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    tick_d = (div_d == DIV_LAST);
  end

  always_ff @(posedge MHz or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debouncer and press-edge detector
  // ---------------------------------------------------------------------------
  logic [2:0] lvl_vec;
  logic [2:0] press_vec;

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    logic [STABLE-1:0] shift_q, shift_d;
    logic              lvl_q, lvl_d;
    logic              press_q, press_d;

    always_comb begin
      shift_d = shift_q;
      lvl_d   = lvl_q;
      if (tick_q) begin
        shift_d = {shift_q[STABLE-2:0], key_in[gi]};
        // The level follows the freshly shifted history, so it moves on the
        // same edge as the shift register; mixed histories hold the level.
        if (&shift_d) begin
          lvl_d = 1'b1;
        end else if (~|shift_d) begin
          lvl_d = 1'b0;
        end
      end
      // Rising edge of the level only; releases produce nothing.
      press_d = lvl_d & ~lvl_q;
    end

    always_ff @(posedge MHz or negedge rst_n) begin
      if (!rst_n) begin
        shift_q <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
      end else begin
        shift_q <= shift_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
      end
    end

    assign lvl_vec[gi]   = lvl_q;
    assign press_vec[gi] = press_q;
  end

  // ---------------------------------------------------------------------------
  // Modulo up/down counter
  // Priority on a press cycle: clear, then up+down cancel, then up, then down.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
    if (press_vec[2]) begin
      counter_d = '0;
    end else if (press_vec[0] && press_vec[1]) begin
      counter_d = counter_q;
    end else if (press_vec[0]) begin
      if (counter_q >= CNT_MAX) begin
        counter_d = '0;
        wrap_d    = 1'b1;
      end else begin
        counter_d = counter_q + WIDTH'(1);
      end
    end else if (press_vec[1]) begin
      if (counter_q == '0) begin
        counter_d = CNT_MAX;
        wrap_d    = 1'b1;
      end else begin
        counter_d = counter_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge MHz or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign counter = counter_q;
  assign key_lvl = lvl_vec;
  assign wrap    = wrap_q;
  assign tick    = tick_q;
  assign led     = 1'b1;

endmodule
